// File: rtl/bullet_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bullet_pkg
// Description : Shared constants for the bullet pool: per-type speed and
//               cooldown tables, type width and controller state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package bullet_pkg;

  localparam int NUM_TYPES = 5;
  localparam int TYPE_W    = 3;
  localparam int SPEED_W   = 4;
  localparam int CD_W      = 5;

  // Pixels advanced per frame, indexed by bullet type.
  localparam logic [SPEED_W-1:0] SPEED_TBL [NUM_TYPES] = '{4'd4, 4'd6, 4'd8, 4'd3, 4'd5};
  // Frames between accepted shots, indexed by bullet type.
  localparam logic [CD_W-1:0] COOLDOWN_TBL [NUM_TYPES] = '{5'd8, 5'd12, 5'd20, 5'd4, 5'd30};

  typedef enum logic [0:0] {
    READY    = 1'b0,
    COOLDOWN = 1'b1
  } fsm_state_t;

  // Out-of-range selector codes fall back to the basic shot.
  function automatic logic [TYPE_W-1:0] mask_type(input logic [4:0] t);
    mask_type = (t > 5'd4) ? '0 : t[TYPE_W-1:0];
  endfunction

  function automatic logic [SPEED_W-1:0] speed_of(input logic [TYPE_W-1:0] t);
    case (t)
      3'd1:    speed_of = SPEED_TBL[1];
      3'd2:    speed_of = SPEED_TBL[2];
      3'd3:    speed_of = SPEED_TBL[3];
      3'd4:    speed_of = SPEED_TBL[4];
      default: speed_of = SPEED_TBL[0];
    endcase
  endfunction

  function automatic logic [CD_W-1:0] cooldown_of(input logic [TYPE_W-1:0] t);
    case (t)
      3'd1:    cooldown_of = COOLDOWN_TBL[1];
      3'd2:    cooldown_of = COOLDOWN_TBL[2];
      3'd3:    cooldown_of = COOLDOWN_TBL[3];
      3'd4:    cooldown_of = COOLDOWN_TBL[4];
      default: cooldown_of = COOLDOWN_TBL[0];
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/bullet_slot.sv
`default_nettype none
// ============================================================================
// Module      : bullet_slot
// Description : One bullet: active/position/type registers, spawn load,
//               per-frame motion, off-screen kill and collision clear.
// Revision    : 1.0 - initial release
// ============================================================================
module bullet_slot
  import bullet_pkg::*;
#(
  parameter int X_W      = 10,
  parameter int Y_W      = 10,
  parameter int SCREEN_W = 640
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spawn,
  input  logic [X_W-1:0]    spawn_x,
  input  logic [Y_W-1:0]    spawn_y,
  input  logic [TYPE_W-1:0] spawn_kind,
  input  logic              tick,
  input  logic              clear,
  output logic              act,
  output logic [X_W-1:0]    pos_x,
  output logic [Y_W-1:0]    pos_y,
  output logic [TYPE_W-1:0] kind
);

  logic              r_active;
  logic [X_W-1:0]    r_x;
  logic [Y_W-1:0]    r_y;
  logic [TYPE_W-1:0] r_type;

  // One extra bit so the step past the screen edge cannot wrap.
  logic [X_W:0] w_x_next;
  logic         w_offscreen;

  assign w_x_next    = {1'b0, r_x} + (X_W+1)'(speed_of(r_type));
  assign w_offscreen = (w_x_next >= (X_W+1)'(SCREEN_W));

  // Spawn only targets free slots; otherwise a clear beats motion on the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_active <= 1'b0;
      r_x      <= '0;
      r_y      <= '0;
      r_type   <= '0;
    end else if (spawn) begin
      r_active <= 1'b1;
      r_x      <= spawn_x;
      r_y      <= spawn_y;
      r_type   <= spawn_kind;
    end else if (r_active && clear) begin
      r_active <= 1'b0;
    end else if (r_active && tick) begin
      if (w_offscreen) begin
        r_active <= 1'b0;
      end else begin
        r_x <= w_x_next[X_W-1:0];
      end
    end
  end

  assign act   = r_active;
  assign pos_x = r_x;
  assign pos_y = r_y;
  assign kind  = r_type;

endmodule
`default_nettype wire

// File: rtl/bullet_pool.sv
`default_nettype none
// ============================================================================
// Module      : bullet_pool
// Description : Player bullet pool. Allocates the lowest free slot on fire,
//               enforces the per-type cooldown and advances live bullets on
//               each frame tick.
//               Optional macro BULLET_POOL_BURST_EN: type 4 spawns a pair of
//               bullets at player_y -/+ 8 in the two lowest free slots.
// Revision    : 1.0 - initial release
// ============================================================================
module bullet_pool
  import bullet_pkg::*;
#(
  parameter int SLOTS     = 4,
  parameter int X_W       = 10,
  parameter int Y_W       = 10,
  parameter int SCREEN_W  = 640,
  parameter int MUZZLE_DX = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame_tick,
  input  logic                    fire,
  input  logic [4:0]              bullet_type,
  input  logic [X_W-1:0]          player_x,
  input  logic [Y_W-1:0]          player_y,
  input  logic [SLOTS-1:0]        hit_clear,
  output logic [SLOTS-1:0]        slot_active,
  output logic [SLOTS*X_W-1:0]    slot_x,
  output logic [SLOTS*Y_W-1:0]    slot_y,
  output logic [SLOTS*TYPE_W-1:0] slot_type,
  output logic                    fire_ack,
  output logic                    fire_drop
);

  fsm_state_t        r_state;
  fsm_state_t        w_state_next;
  logic [CD_W-1:0]   r_cnt;
  logic [CD_W-1:0]   w_cnt_next;
  logic              r_ack;
  logic              r_drop;
  logic              w_ack_next;
  logic              w_drop_next;

  logic [SLOTS-1:0]  w_active;
  logic [SLOTS-1:0]  w_first;
  logic [SLOTS-1:0]  w_second;
  logic              w_found0;
  logic              w_found1;
  logic [SLOTS-1:0]  w_spawn_lo;
  logic [SLOTS-1:0]  w_spawn_hi;
  logic [TYPE_W-1:0] w_type;
  logic              w_burst;
  logic              w_can_fire;
  logic [X_W-1:0]    w_spawn_x;
  logic [Y_W-1:0]    w_y_lo;
  logic [Y_W-1:0]    w_y_hi;

  assign w_type    = mask_type(bullet_type);
  assign w_spawn_x = player_x + X_W'(MUZZLE_DX);
  assign w_y_hi    = player_y + Y_W'(8);
  assign w_y_lo    = w_burst ? (player_y - Y_W'(8)) : player_y;

  // Lowest and second-lowest free slots, taken from registered state only.
  always_comb begin
    w_first  = '0;
    w_second = '0;
    w_found0 = 1'b0;
    w_found1 = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin
      if (!w_active[i]) begin
        if (!w_found0) begin
          w_first[i] = 1'b1;
          w_found0   = 1'b1;
        end else if (!w_found1) begin
          w_second[i] = 1'b1;
          w_found1    = 1'b1;
        end
      end
    end
  end

  // Next-state, cooldown counter and spawn decode.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_ack_next   = 1'b0;
    w_drop_next  = 1'b0;
    w_spawn_lo   = '0;
    w_spawn_hi   = '0;
`ifdef BULLET_POOL_BURST_EN
    w_burst      = (w_type == 3'd4);
`else
    w_burst      = 1'b0;
`endif
    w_can_fire   = w_burst ? w_found1 : w_found0;
    case (r_state)
      READY: begin
        if (fire) begin
          if (w_can_fire) begin
            w_ack_next   = 1'b1;
            w_spawn_lo   = w_first;
            w_spawn_hi   = w_burst ? w_second : '0;
            w_cnt_next   = cooldown_of(w_type);
            w_state_next = COOLDOWN;
          end else begin
            w_drop_next = 1'b1;
          end
        end
      end
      COOLDOWN: begin
        w_drop_next = fire;
        if (frame_tick) begin
          if (r_cnt <= CD_W'(1)) begin
            w_cnt_next   = '0;
            w_state_next = READY;
          end else begin
            w_cnt_next = r_cnt - CD_W'(1);
          end
        end
      end
      default: begin
        w_state_next = READY;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Controller state, cooldown counter and registered fire handshakes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= READY;
      r_cnt   <= '0;
      r_ack   <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_ack   <= w_ack_next;
      r_drop  <= w_drop_next;
    end
  end

  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    bullet_slot #(
      .X_W      (X_W),
      .Y_W      (Y_W),
      .SCREEN_W (SCREEN_W)
    ) u_slot (
      .clk        (clk),
      .rst        (rst),
      .spawn      (w_spawn_lo[i] | w_spawn_hi[i]),
      .spawn_x    (w_spawn_x),
      .spawn_y    (w_spawn_hi[i] ? w_y_hi : w_y_lo),
      .spawn_kind (w_type),
      .tick       (frame_tick),
      .clear      (hit_clear[i]),
      .act        (w_active[i]),
      .pos_x      (slot_x[i*X_W +: X_W]),
      .pos_y      (slot_y[i*Y_W +: Y_W]),
      .kind       (slot_type[i*TYPE_W +: TYPE_W])
    );
  end

  assign slot_active = w_active;
  assign fire_ack    = r_ack;
  assign fire_drop   = r_drop;

endmodule
`default_nettype wire

// File: doc/bullet_pool.md
# bullet_pool

Bullet pool and motion engine for the player's weapon. Sits directly downstream of the bullet-type selector: consumes its 5-bit selected type plus a fire request, allocates a free bullet slot, and advances every live bullet once per video frame until it leaves the screen or is cleared by collision logic. Its slot outputs feed the sprite renderer and the hit detector.

## Interface
Parameters:
- SLOTS, 4: number of simultaneous bullets.
- X_W, 10: x coordinate width.
- Y_W, 10: y coordinate width.
- SCREEN_W, 640: first off-screen x; a bullet at x >= SCREEN_W dies.
- MUZZLE_DX, 16: spawn x offset from player_x.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- frame_tick  in  1  one-cycle pulse per frame.
- fire  in  1  one-cycle fire request.
- bullet_type  in  5  selected type from the selector, 0..4.
- player_x  in  X_W  player x.
- player_y  in  Y_W  player y.
- hit_clear  in  SLOTS  per-slot kill from collision logic.
- slot_active  out  SLOTS  live flag per slot.
- slot_x  out  SLOTS*X_W  packed x; slot i at [i*X_W +: X_W].
- slot_y  out  SLOTS*Y_W  packed y.
- slot_type  out  SLOTS*3  packed type.
- fire_ack  out  1  one-cycle pulse when a fire request spawned a bullet.
- fire_drop  out  1  one-cycle pulse when a fire request was rejected.

## Operation
- Per-type table, indexed by type: speed {4,6,8,3,5} px/frame; cooldown {8,12,20,4,30} frames. bullet_type > 4 is treated as 0.
- Controller FSM has two states:
  - READY: fire is accepted when a free slot exists. The free slot is the lowest index with slot_active=0, evaluated from registered state at the start of the cycle.
  - COOLDOWN: cooldown counter != 0; any fire gives fire_drop.
- Transitions:
  - READY -> COOLDOWN on an accepted fire; the counter loads cooldown[type].
  - COOLDOWN -> READY when the counter reaches 0.
  - The counter decrements by 1 on each frame_tick.
- Spawn loads x = player_x + MUZZLE_DX, y = player_y, type = the masked type, and active = 1.
- fire in READY with no free slot: fire_drop, the state stays READY, and no cooldown is loaded.
- Motion on frame_tick, for each active slot:
  - x_next = x + speed, computed X_W+1 bits wide.
  - If x_next >= SCREEN_W, the slot clears (active=0) and x is left unchanged.
  - A spawn position already >= SCREEN_W clears the slot on the next frame_tick.
- Simultaneous events:
  - hit_clear and frame_tick on the same slot: the clear wins.
  - A slot freed by hit_clear in cycle N is not allocatable until cycle N+1.
  - fire and frame_tick in the same cycle: the bullet spawns and does not move on that tick. In the same cycle the cooldown loads and does not decrement.
  - hit_clear on an inactive slot has no effect.

## Timing
- Reset values: slot_active=0, slot_x=0, slot_y=0, slot_type=0, fire_ack=0, fire_drop=0, FSM=READY, counter=0.
- Reset asserted mid-flight kills all bullets immediately (asynchronous).
- fire sampled at edge N:
  - slot outputs, fire_ack and fire_drop are valid after edge N.
  - fire_ack and fire_drop are exactly 1 cycle wide and never both high.
- Motion updates are registered at the frame_tick edge, a 1-cycle latency.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- BULLET_POOL_BURST_EN
  - Defined: type 4 spawns two bullets in the two lowest free slots, at y = player_y - 8 and player_y + 8 (wrapping modulo 2^Y_W). It needs two free slots; with only one free, the result is fire_drop and no spawn. There is a single fire_ack and a single cooldown load.
  - Undefined: type 4 spawns one bullet like every other type.

## Structure
- Package bullet_pkg holds:
  - the speed and cooldown tables as constant arrays;
  - NUM_TYPES=5 and the 3-bit type width;
  - the FSM state enum {READY, COOLDOWN}.
- Sub-module bullet_slot, one instance per slot, holds:
  - the active/x/y/type registers;
  - spawn load, motion, off-screen kill and clear priority.
- The top level holds the free-slot priority encoder, the FSM, the cooldown counter and output packing.

## Test plan
- Reset, then fire with type 0 and player (100,200). Expect fire_ack; slot 0 active at (116,200) with type 0; counter 8. A second fire before 8 frame_ticks gives fire_drop.
- Type 2 bullet at x=116, then 65 frame_ticks. Expect x = 116 + 8*65 = 636 while live; on the next tick 644 >= 640, so slot_active[0] falls.
- Type 3 with cooldown 4: fill all 4 slots, waiting 4 ticks between fires. The 5th fire gives fire_drop and the FSM stays READY. Then pulse hit_clear[1]; a fire two cycles later lands in slot 1.
- hit_clear[0] together with frame_tick on live slot 0: slot 0 is inactive and x is unchanged. fire together with frame_tick: the new bullet sits at its spawn x.
- bullet_type=7 behaves as type 0 (speed 4, cooldown 8). Assert rst mid-flight: all outputs go 0 before the next clk edge.
- With BULLET_POOL_BURST_EN and type 4 at player (50,100): slots 0 and 1 are at (66,92) and (66,108) with one fire_ack. With a single free slot: fire_drop.
